tx_ip_csum: RTL and testbench

//  Transmit-side IPv4 header checksum generator and inserter. Sits in the Ethernet TX

---
 rtl/txip_defs.sv | 26 ++
 rtl/txbyte_delay.sv | 35 +++
 rtl/tx_ip_csum.sv | 197 +++++++++++++++++++
 tb/tb_tx_ip_csum.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/txip_defs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | txip_defs : shared constants and types for the TX IPv4 checksum inserter   |
// | Rev 1.0   : initial release                                                |
// +----------------------------------------------------------------------------+
package txip_defs;

  localparam logic [15:0] ETHERTYPE_IPV4     = 16'h0800;
  localparam int          ETH_HDR_LEN        = 14;
  localparam int          IP_CSUM_OFS        = 24;
  localparam int          IP_MIN_IHL         = 5;
  localparam int          TXIPCSUM_MIN_DELAY = 52;
  localparam int          TXIPCSUM_MAX_DELAY = 64;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } txbyte_t;

  // Folds a raw partial sum (at most 17'h1fffe) into 16 bits; never re-overflows.
  function automatic logic [15:0] csum_fold(input logic [16:0] s);
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/txbyte_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | txbyte_delay : DELAY-deep valid+data shift line with asynchronous clear    |
// | Rev 1.0      : initial release                                             |
// +----------------------------------------------------------------------------+
module txbyte_delay
  import txip_defs::*;
#(
  parameter int DELAY = 56
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  txbyte_t i_byte,
  output txbyte_t o_byte
);

  txbyte_t [DELAY-1:0] line_q;
  txbyte_t [DELAY-1:0] line_d;

  always_comb begin
    line_d = {line_q[DELAY-2:0], i_byte};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign o_byte = line_q[DELAY-1];

endmodule
`default_nettype wire

// File: rtl/tx_ip_csum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_ip_csum : TX IPv4 header checksum generator/inserter, DELAY-cycle path  |
// |              Optional frame counter port o_count: define TXIPCSUM_COUNT_EN |
// | Rev 1.0    : initial release                                               |
// +----------------------------------------------------------------------------+
module tx_ip_csum
  import txip_defs::*;
#(
  parameter int DELAY = 56  // legal range 52..64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_v,
  input  logic [7:0]  i_d,
  output logic        o_v,
  output logic [7:0]  o_d
`ifdef TXIPCSUM_COUNT_EN
  ,
  output logic [15:0] o_count
`endif
);

  localparam logic [6:0] c_n_max      = 7'd127;
  localparam logic [6:0] c_type_hi    = 7'(ETH_HDR_LEN - 2);
  localparam logic [6:0] c_type_lo    = 7'(ETH_HDR_LEN - 1);
  localparam logic [6:0] c_hdr_start  = 7'(ETH_HDR_LEN);
  localparam logic [6:0] c_first_word = 7'(ETH_HDR_LEN + 1);
  localparam logic [6:0] c_csum_hi    = 7'(IP_CSUM_OFS);
  localparam logic [6:0] c_csum_lo    = 7'(IP_CSUM_OFS + 1);

  txbyte_t in_byte;
  txbyte_t dl_byte;

  assign in_byte = '{v: i_v, d: i_d};

  txbyte_delay #(.DELAY(DELAY)) u_delay (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_byte  (in_byte),
    .o_byte  (dl_byte)
  );

  logic [6:0]  n_q, n_d;
  logic        en_q, en_d;
  logic        b12_ok_q, b12_ok_d;
  logic        type_ok_q, type_ok_d;
  logic        elig_q, elig_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [7:0]  hi_q, hi_d;
  logic [16:0] acc_q, acc_d;
  logic        fin_q, fin_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic [6:0]  on_q, on_d;
`ifdef TXIPCSUM_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  logic [6:0]  last_idx;
  logic        add_word;
  logic        consume;
  logic [15:0] word;
  logic [15:0] base;

  always_comb begin
    n_d       = n_q;
    en_d      = en_q;
    b12_ok_d  = b12_ok_q;
    type_ok_d = type_ok_q;
    elig_d    = elig_q;
    ihl_d     = ihl_q;
    hi_d      = hi_q;
    acc_d     = acc_q;
    fin_d     = 1'b0;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    on_d      = on_q;
`ifdef TXIPCSUM_COUNT_EN
    cnt_d     = cnt_q;
`endif

    // n_q is the index of the byte currently on i_d
    if (!i_v) begin
      n_d = '0;
    end else if (n_q != c_n_max) begin
      n_d = n_q + 7'd1;
    end

    if (i_v) begin
      if (n_q == '0) begin
        en_d   = i_en;
        elig_d = 1'b0;
      end
      if (n_q == c_type_hi) begin
        b12_ok_d = (i_d == ETHERTYPE_IPV4[15:8]);
      end
      if (n_q == c_type_lo) begin
        type_ok_d = b12_ok_q && (i_d == ETHERTYPE_IPV4[7:0]);
      end
      if (n_q == c_hdr_start) begin
        ihl_d  = i_d[3:0];
        elig_d = en_q && type_ok_q && (i_d[7:4] == 4'd4) &&
                 (i_d[3:0] >= 4'(IP_MIN_IHL));
      end
      if (!n_q[0]) begin
        hi_d = (n_q == c_csum_hi) ? 8'h00 : i_d;
      end
    end

    last_idx = 7'(ETH_HDR_LEN - 1) + {1'b0, ihl_q, 2'b00};
    add_word = i_v && elig_q && n_q[0] && (n_q >= c_first_word) && (n_q <= last_idx);
    word     = {hi_q, (n_q == c_csum_lo) ? 8'h00 : i_d};
    base     = (n_q == c_first_word) ? 16'h0000 : csum_fold(acc_q);

    if (add_word) begin
      acc_d = {1'b0, base} + {1'b0, word};
      fin_d = (n_q == last_idx);
    end

    // Consume has priority: a checksum completing in the same cycle is dropped
    consume = dl_byte.v && pend_v_q && (on_q == c_csum_lo);
    if (consume) begin
      pend_v_d = 1'b0;
    end else if (fin_q) begin
      pend_v_d = 1'b1;
      pend_d   = ~csum_fold(acc_q);
    end

    if (!dl_byte.v) begin
      on_d = '0;
    end else if (on_q != c_n_max) begin
      on_d = on_q + 7'd1;
    end

`ifdef TXIPCSUM_COUNT_EN
    if (consume) begin
      cnt_d = cnt_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      n_q       <= '0;
      en_q      <= 1'b0;
      b12_ok_q  <= 1'b0;
      type_ok_q <= 1'b0;
      elig_q    <= 1'b0;
      ihl_q     <= '0;
      hi_q      <= '0;
      acc_q     <= '0;
      fin_q     <= 1'b0;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      on_q      <= '0;
`ifdef TXIPCSUM_COUNT_EN
      cnt_q     <= '0;
`endif
    end else begin
      n_q       <= n_d;
      en_q      <= en_d;
      b12_ok_q  <= b12_ok_d;
      type_ok_q <= type_ok_d;
      elig_q    <= elig_d;
      ihl_q     <= ihl_d;
      hi_q      <= hi_d;
      acc_q     <= acc_d;
      fin_q     <= fin_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      on_q      <= on_d;
`ifdef TXIPCSUM_COUNT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  always_comb begin
    o_v = dl_byte.v;
    o_d = dl_byte.d;
    if (dl_byte.v && pend_v_q) begin
      if (on_q == c_csum_hi) begin
        o_d = pend_q[15:8];
      end else if (on_q == c_csum_lo) begin
        o_d = pend_q[7:0];
      end
    end
  end

`ifdef TXIPCSUM_COUNT_EN
  assign o_count = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_ip_csum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tx_ip_csum : scoreboard bench with reference checksum model             |
// | Rev 1.0       : initial release                                            |
// +----------------------------------------------------------------------------+
module tb_tx_ip_csum;

  localparam int DELAY = 56;

  typedef logic [7:0] bytes_t[];
  typedef struct {
    int         cyc;
    logic [7:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        iv  = 1'b0;
  logic [7:0]  id  = 8'h00;
  logic        ov;
  logic [7:0]  od;
`ifdef TXIPCSUM_COUNT_EN
  logic [15:0] cnt;
`endif

  exp_t sb[$];
  int   cyc       = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   model_cnt = 0;

  always #5 clk = ~clk;

  tx_ip_csum #(.DELAY(DELAY)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_en    (en),
    .i_v     (iv),
    .i_d     (id),
    .o_v     (ov),
    .o_d     (od)
`ifdef TXIPCSUM_COUNT_EN
    ,
    .o_count (cnt)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every byte due this cycle must appear; otherwise o_v must be low
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (ov !== 1'b1 || od !== e.d) begin
        n_fail++;
        $display("FAIL out_byte cyc=%0d: got v=%b d=%02h, required v=1 d=%02h",
                 cyc, ov, od, e.d);
      end
    end else if (ov !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle cyc=%0d: got v=%b d=%02h, required v=0", cyc, ov, od);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bytes_t mk_frame(int len, logic [15:0] etype, logic [3:0] ver,
                                      logic [3:0] ihl);
    bytes_t f;
    f = new[len];
    for (int i = 0; i < len; i++) f[i] = 8'($urandom);
    f[12] = etype[15:8];
    f[13] = etype[7:0];
    if (len > 14) f[14] = {ver, ihl};
    return f;
  endfunction

  // Reference: ones-complement sum of header words with checksum field as zero
  function automatic bytes_t model(input bytes_t fr, input logic fen, output bit elig);
    bytes_t      ex;
    int unsigned s;
    int          hl;
    logic [3:0]  ihl;
    logic [7:0]  hi, lo;
    logic [15:0] c;
    ex   = fr;
    elig = 1'b0;
    if (fr.size() > 14) begin
      ihl = fr[14][3:0];
      hl  = 4 * int'(ihl);
      if (fen && fr[12] == 8'h08 && fr[13] == 8'h00 && fr[14][7:4] == 4'd4 &&
          ihl >= 4'd5 && fr.size() >= 14 + hl) begin
        s = 0;
        for (int k = 14; k < 14 + hl; k += 2) begin
          hi = (k == 24) ? 8'h00 : fr[k];
          lo = (k + 1 == 25) ? 8'h00 : fr[k+1];
          s += {16'h0, hi, lo};
        end
        while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
        c     = ~s[15:0];
        ex[24] = c[15:8];
        ex[25] = c[7:0];
        elig  = 1'b1;
      end
    end
    return ex;
  endfunction

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      iv = 1'b0;
      id = 8'h00;
      en = 1'b0;
    end
  endtask

  task automatic send(bytes_t fr, logic fen, bytes_t ex, bit elig, int gap);
    for (int i = 0; i < fr.size(); i++) begin
      @(posedge clk); #1;
      iv = 1'b1;
      id = fr[i];
      en = fen;
      sb.push_back('{cyc + DELAY, ex[i]});
    end
    if (elig) model_cnt++;
    idle(gap);
  endtask

  task automatic send_auto(bytes_t fr, logic fen, int gap);
    bytes_t ex;
    bit     elig;
    ex = model(fr, fen, elig);
    send(fr, fen, ex, elig, gap);
  endtask

  task automatic reset_in_frame(bytes_t fr, logic fen, int at);
    for (int i = 0; i < at; i++) begin
      @(posedge clk); #1;
      iv = 1'b1;
      id = fr[i];
      en = fen;
      sb.push_back('{cyc + DELAY, fr[i]});
    end
    @(posedge clk); #1;
    iv  = 1'b0;
    en  = 1'b0;
    rst = 1'b1;
    sb.delete();
    model_cnt = 0;
    idle(3);
    rst = 1'b0;
    idle(2);
  endtask

  initial begin : main
    logic [7:0] hdr1 [20];
    bytes_t     fr, ex;
    int         kind, ihl, len;

    hdr1 = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
             8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (ov !== 1'b0 || od !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%02h, required v=0 d=00", ov, od);
    end
`ifdef TXIPCSUM_COUNT_EN
    n_tests++;
    if (cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d, required 0", cnt);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);

    // Known header with literal checksum b8 61
    fr = mk_frame(60, 16'h0800, 4'd4, 4'd5);
    for (int i = 0; i < 20; i++) fr[14+i] = hdr1[i];
    ex = fr;
    ex[24] = 8'hb8;
    ex[25] = 8'h61;
    send(fr, 1'b1, ex, 1'b1, 1);
    send(fr, 1'b0, fr, 1'b0, 2);

    send_auto(mk_frame(60, 16'h0806, 4'd4, 4'd5), 1'b1, 1);
    send_auto(mk_frame(60, 16'h0800, 4'd4, 4'd4), 1'b1, 1);

    fr = mk_frame(80, 16'h0800, 4'd4, 4'd15);
    for (int i = 34; i < 74; i++) fr[i] = 8'h00;
    fr[72] = 8'h12;
    fr[73] = 8'h34;
    fr[24] = 8'h00;
    fr[25] = 8'h00;
    send_auto(fr, 1'b1, 1);

    for (int i = 0; i < 4; i++) send_auto(mk_frame(60, 16'h0800, 4'd4, 4'd5), 1'b1, 1);

    reset_in_frame(mk_frame(60, 16'h0800, 4'd4, 4'd5), 1'b1, 30);
    send_auto(mk_frame(60, 16'h0800, 4'd4, 4'd5), 1'b0, 1);
    reset_in_frame(mk_frame(60, 16'h0800, 4'd4, 4'd5), 1'b1, 40);
    send_auto(mk_frame(60, 16'h0800, 4'd4, 4'd5), 1'b0, 1);
    send_auto(mk_frame(60, 16'h0800, 4'd4, 4'd5), 1'b1, 1);

    send_auto(mk_frame(20, 16'h0800, 4'd4, 4'd5), 1'b1, 2);
    send_auto(mk_frame(60, 16'h0800, 4'd4, 4'd5), 1'b0, 1);

    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      ihl  = $urandom_range(5, 15);
      if (kind == 2) ihl = $urandom_range(0, 4);
      len = 14 + 4 * ihl + $urandom_range(0, 30);
      if (len < 60) len = 60;
      case (kind)
        0:       fr = mk_frame(len, 16'h0806, 4'd4, 4'(ihl));
        1:       fr = mk_frame(len, 16'h0800, 4'd6, 4'(ihl));
        default: fr = mk_frame(len, 16'h0800, 4'd4, 4'(ihl));
      endcase
      send_auto(fr, ($urandom_range(0, 4) != 0), $urandom_range(1, 3));
    end

    idle(DELAY + 4);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d bytes outstanding, required 0", sb.size());
    end
`ifdef TXIPCSUM_COUNT_EN
    n_tests++;
    if (cnt !== 16'(model_cnt)) begin
      n_fail++;
      $display("FAIL o_count: got %0d, required %0d", cnt, model_cnt);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
